gate_vec_pipe: RTL and testbench

Registered, parametrised vector logic unit: applies one of eight bitwise gate functions (NOT, AND, OR, XOR, NAND, NOR, XNOR, pass) to two WIDTH-bit operands. It has valid/ready flow control on both input and output. An accumulate mode folds a multi-beat burst into a single result and reports the number of beats. It is the sequential, vector-wide successor to the single-bit gate primitives and sits between streaming producers and consumers in the datapath library.

---
 rtl/gate_vec_pipe.sv | 111 +++++++++++
 tb/tb_gate_vec_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vec_pipe.sv
// Registered vector gate unit with valid/ready handshakes on both sides.
// Accumulate mode folds a multi-beat burst into one result plus a saturating beat count.
module gate_vec_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc,
   input  logic             last,
   input  logic [WIDTH-1:0] e1,
   input  logic [WIDTH-1:0] e2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [CNTW-1:0]  cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc_q;
   logic [2:0]       op_q;
   logic [CNTW-1:0]  beat_cnt;

   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] f_direct;
   logic [WIDTH-1:0] f_fold;
   logic [CNTW-1:0]  cnt_inc;

   function automatic logic [WIDTH-1:0] gate_fn(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      case (sel)
         3'd0:    r = ~a;
         3'd1:    r = a & b;
         3'd2:    r = a | b;
         3'd3:    r = a ^ b;
         3'd4:    r = ~(a & b);
         3'd5:    r = ~(a | b);
         3'd6:    r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   // Burst beats fold e1 into the running accumulator using the op captured on the first beat.
   assign f_direct = gate_fn(op, e1, e2);
   assign f_fold   = gate_fn(op_q, e1, acc_q);
   assign cnt_inc  = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNTW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc_q     <= '0;
         op_q      <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         s         <= '0;
         cnt       <= '0;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (acc && !last) begin
                  acc_q     <= f_direct;
                  op_q      <= op;
                  beat_cnt  <= CNTW'(1);
                  state     <= ACC;
                  out_valid <= 1'b0;
               end else begin
                  s         <= f_direct;
                  cnt       <= CNTW'(1);
                  out_valid <= 1'b1;
               end
            end
            ACC: begin
               if (last) begin
                  s         <= f_fold;
                  cnt       <= cnt_inc;
                  out_valid <= 1'b1;
                  acc_q     <= '0;
                  beat_cnt  <= '0;
                  state     <= IDLE;
               end else begin
                  acc_q     <= f_fold;
                  beat_cnt  <= cnt_inc;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gate_vec_pipe.sv
// Self-checking bench for gate_vec_pipe: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_gate_vec_pipe;

   localparam int W    = 8;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic          acc;
   logic          last;
   logic [W-1:0]  e1;
   logic [W-1:0]  e2;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  s;
   logic [CW-1:0] cnt;

   int checks   = 0;
   int failures = 0;

   gate_vec_pipe #(.WIDTH(W), .CNTW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .acc       (acc),
      .last      (last),
      .e1        (e1),
      .e2        (e2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int gate_ref(input int o, input int a, input int b);
      int r;
      case (o)
         0: r = ~a;
         1: r = a & b;
         2: r = a | b;
         3: r = a ^ b;
         4: r = ~(a & b);
         5: r = ~(a | b);
         6: r = ~(a ^ b);
         default: r = a;
      endcase
      return r & ((1 << W) - 1);
   endfunction

   // Transaction-level model: burst tracked as "open burst + unbounded beat count", clamped on output.
   logic m_valid;
   int   m_s, m_cnt;
   logic m_busy;
   int   m_acc, m_op, m_n;

   always @(posedge clk or posedge rst) begin : model
      int   r, n;
      logic produce;
      if (rst) begin
         m_valid <= 1'b0; m_s <= 0; m_cnt <= 0;
         m_busy  <= 1'b0; m_acc <= 0; m_op <= 0; m_n <= 0;
      end else begin
         produce = 1'b0; r = 0; n = 0;
         if (in_valid && (!m_valid || out_ready)) begin
            if (!m_busy) begin
               r = gate_ref(int'(op), int'(e1), int'(e2));
               if (acc && !last) begin
                  m_busy <= 1'b1; m_acc <= r; m_op <= int'(op); m_n <= 1;
               end else begin
                  produce = 1'b1; n = 1;
               end
            end else begin
               r = gate_ref(m_op, int'(e1), m_acc);
               n = m_n + 1;
               if (last) begin
                  produce = 1'b1; m_busy <= 1'b0;
               end else begin
                  m_acc <= r; m_n <= n;
               end
            end
         end
         if (produce) begin
            m_valid <= 1'b1; m_s <= r; m_cnt <= (n > CMAX) ? CMAX : n;
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("s", int'(s), m_s);
      chk("cnt", int'(cnt), m_cnt);
   end

   task automatic send(input int o, input logic a, input logic l, input int x1, input int x2);
      int t;
      in_valid = 1'b1; op = 3'(o); acc = a; last = l; e1 = W'(x1); e2 = W'(x2);
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   int sweep_exp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};

   initial begin
      rst = 1'b1; in_valid = 1'($urandom); op = 3'($urandom); acc = 1'($urandom);
      last = 1'($urandom); e1 = W'($urandom); e2 = W'($urandom); out_ready = 1'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_s", int'(s), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_out_valid", int'(out_valid), 0);
      chk("post_rst_s", int'(s), 0);
      chk("post_rst_cnt", int'(cnt), 0);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         send(i, 1'b0, 1'b0, 8'hF0, 8'hCC);
         chk("sweep_valid", int'(out_valid), 1);
         chk("sweep_s", int'(s), sweep_exp[i]);
         chk("sweep_cnt", int'(cnt), 1);
      end

      send(3, 1'b0, 1'b0, 8'hF0, 8'hCC);
      chk("bp_s0", int'(s), 8'h3C);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd1; acc = 1'b0; last = 1'b0; e1 = 8'hF0; e2 = 8'hCC;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_s_hold", int'(s), 8'h3C);
         chk("bp_cnt_hold", int'(cnt), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_release_valid", int'(out_valid), 1);
      chk("bp_release_s", int'(s), 8'hC0);

      send(3, 1'b1, 1'b0, 8'h01, 8'h02);
      chk("xor_b1_no_out", int'(out_valid), 0);
      send(1, 1'b0, 1'b0, 8'h04, 8'h00);
      chk("xor_b2_no_out", int'(out_valid), 0);
      send(1, 1'b0, 1'b1, 8'h08, 8'h00);
      chk("xor_valid", int'(out_valid), 1);
      chk("xor_s", int'(s), 8'h0F);
      chk("xor_cnt", int'(cnt), 3);
      @(posedge clk); #1;

      send(2, 1'b1, 1'b0, 8'h11, 8'h22);
      send(2, 1'b0, 1'b0, 8'h44, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_post_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      send(1, 1'b1, 1'b0, 8'hFF, 8'h3C);
      send(1, 1'b0, 1'b1, 8'h0F, 8'h00);
      chk("and_s", int'(s), 8'h0C);
      chk("and_cnt", int'(cnt), 2);

      for (int i = 0; i < 300; i++)
         send(2, (i == 0), (i == 299), 1 << (i % 8), 0);
      chk("sat_s", int'(s), 8'hFF);
      chk("sat_cnt", int'(cnt), 255);
      send(6, 1'b0, 1'b0, 8'h5A, 8'h5A);
      chk("sat_after_s", int'(s), 8'hFF);
      chk("sat_after_cnt", int'(cnt), 1);

      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom);
         acc       = ($urandom_range(0, 2) == 0);
         last      = ($urandom_range(0, 3) == 0);
         e1        = W'($urandom);
         e2        = W'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
